c17_vector_sequencer: RTL and testbench

//  Built-in test controller for the c17 gate-level block.
//  - Drives 5-bit stimulus onto I1,I2,I3,I6,I7 in exhaustive (counter) or pseudo-random (LFSR) order.
//  - Waits a programmable settle time, then samples O22/O23.
//  - Compares the sample against an internal golden c17 model, counts mismatches and records the first failure.
//  - Sits beside the c17 instance and is started and read by the top-level test logic.

---
 rtl/c17_vector_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_c17_vector_sequencer.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/c17_vector_sequencer.sv
// Built-in test controller for the c17 block: applies counter or LFSR vectors,
// waits a settle time, compares O22/O23 with a golden model and logs failures.
module c17_vector_sequencer #(
  parameter int unsigned SETTLE_CYC = 2,
  parameter int unsigned CNT_W      = 8,
  parameter logic [4:0]  LFSR_SEED  = 5'h1F
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             mode,
  input  logic [5:0]       num_vec,
  output logic [4:0]       stim,
  input  logic [1:0]       resp,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_cnt,
  output logic [5:0]       vec_cnt,
  output logic             fail_valid,
  output logic [4:0]       fail_stim,
  output logic [1:0]       fail_resp
);

  localparam int unsigned SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam int unsigned VEC_W = 6;
  localparam logic [4:0]  SEED  = (LFSR_SEED == 5'd0) ? 5'h01 : LFSR_SEED;

  typedef enum logic [2:0] {
    S_IDLE,
    S_APPLY,
    S_SETTLE,
    S_CAPTURE,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [4:0]         stim_q, stim_d;
  logic [4:0]         lfsr_q, lfsr_d;
  logic               mode_q, mode_d;
  logic [VEC_W-1:0]   n_q, n_d;
  logic [VEC_W-1:0]   vec_cnt_q, vec_cnt_d;
  logic [SET_W-1:0]   settle_q, settle_d;
  logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               pass_q, pass_d;
  logic               fail_valid_q, fail_valid_d;
  logic [4:0]         fail_stim_q, fail_stim_d;
  logic [1:0]         fail_resp_q, fail_resp_d;

  // Reference c17 netlist built from two-input NANDs; returns {O23, O22}.
  function automatic logic [1:0] c17_golden(input logic [4:0] v);
    logic a, b, c, d;
    a = ~(v[0] & v[2]);
    b = ~(v[2] & v[3]);
    c = ~(v[1] & b);
    d = ~(b & v[4]);
    return {~(c & d), ~(a & c)};
  endfunction

  always_comb begin
    state_d      = state_q;
    stim_d       = stim_q;
    lfsr_d       = lfsr_q;
    mode_d       = mode_q;
    n_d          = n_q;
    vec_cnt_d    = vec_cnt_q;
    settle_d     = settle_q;
    err_cnt_d    = err_cnt_q;
    pass_d       = pass_q;
    fail_valid_d = fail_valid_q;
    fail_stim_d  = fail_stim_q;
    fail_resp_d  = fail_resp_q;

    // Abort returns to idle but keeps the result registers for readout.
    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      stim_d  = 5'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start && !abort) begin
            mode_d       = mode;
            n_d          = ((num_vec == 6'd0) || (num_vec > 6'd32)) ? 6'd32 : num_vec;
            vec_cnt_d    = '0;
            err_cnt_d    = '0;
            pass_d       = 1'b0;
            fail_valid_d = 1'b0;
            fail_stim_d  = 5'd0;
            fail_resp_d  = 2'd0;
            lfsr_d       = SEED;
            state_d      = S_APPLY;
          end
        end
        S_APPLY: begin
          stim_d   = mode_q ? lfsr_q : vec_cnt_q[4:0];
          settle_d = SET_W'(SETTLE_CYC - 1);
          state_d  = S_SETTLE;
        end
        S_SETTLE: begin
          if (settle_q == '0) begin
            state_d = S_CAPTURE;
          end else begin
            settle_d = settle_q - SET_W'(1);
          end
        end
        S_CAPTURE: begin
          if (resp != c17_golden(stim_q)) begin
            if (err_cnt_q != '1) begin
              err_cnt_d = err_cnt_q + CNT_W'(1);
            end
            if (!fail_valid_q) begin
              fail_valid_d = 1'b1;
              fail_stim_d  = stim_q;
              fail_resp_d  = resp;
            end
          end
          vec_cnt_d = vec_cnt_q + VEC_W'(1);
          // Fibonacci LFSR for x^5 + x^3 + 1.
          lfsr_d    = {lfsr_q[3:0], lfsr_q[4] ^ lfsr_q[2]};
          state_d   = (vec_cnt_d == n_q) ? S_DONE : S_APPLY;
        end
        S_DONE: begin
          pass_d  = (err_cnt_q == '0);
          stim_d  = 5'd0;
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
          stim_d  = 5'd0;
        end
      endcase
    end

    busy_d = (state_d == S_APPLY) || (state_d == S_SETTLE) || (state_d == S_CAPTURE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      stim_q       <= 5'd0;
      lfsr_q       <= SEED;
      mode_q       <= 1'b0;
      n_q          <= '0;
      vec_cnt_q    <= '0;
      settle_q     <= '0;
      err_cnt_q    <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      fail_valid_q <= 1'b0;
      fail_stim_q  <= 5'd0;
      fail_resp_q  <= 2'd0;
    end else begin
      state_q      <= state_d;
      stim_q       <= stim_d;
      lfsr_q       <= lfsr_d;
      mode_q       <= mode_d;
      n_q          <= n_d;
      vec_cnt_q    <= vec_cnt_d;
      settle_q     <= settle_d;
      err_cnt_q    <= err_cnt_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      fail_valid_q <= fail_valid_d;
      fail_stim_q  <= fail_stim_d;
      fail_resp_q  <= fail_resp_d;
    end
  end

  assign stim       = stim_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign err_cnt    = err_cnt_q;
  assign vec_cnt    = vec_cnt_q;
  assign fail_valid = fail_valid_q;
  assign fail_stim  = fail_stim_q;
  assign fail_resp  = fail_resp_q;

endmodule

// File: tb/tb_c17_vector_sequencer.sv
// Scoreboard bench for c17_vector_sequencer: a behavioural c17 (with optional
// stuck-at faults) answers STIM, expected vectors/run results are queued at START.
module tb_c17_vector_sequencer;

  localparam int unsigned SETTLE = 2;
  localparam int unsigned CW     = 8;

  logic          clk = 1'b0;
  logic          rst_n, start, abort, mode;
  logic [5:0]    num_vec;
  logic [4:0]    stim;
  logic [1:0]    resp;
  logic          busy, done, pass, fail_valid;
  logic [CW-1:0] err_cnt;
  logic [5:0]    vec_cnt;
  logic [4:0]    fail_stim;
  logic [1:0]    fail_resp;

  int            fault;     // 0 none, 1 O23 stuck-at-0, 2 O22 stuck-at-1
  longint        cyc = 0;
  int            checks = 0;
  int            failures = 0;

  typedef struct {
    logic [4:0] stim;
    int         err;
  } vec_exp_t;

  typedef struct {
    int         err;
    int         vc;
    bit         fv;
    logic [4:0] fs;
    logic [1:0] fr;
    bit         pass;
    longint     done_cyc;
  } run_exp_t;

  vec_exp_t   vq[$];
  run_exp_t   rq[$];
  logic [4:0] seen[$];
  bit         pass_pending = 0;
  bit         exp_pass;

  c17_vector_sequencer #(.SETTLE_CYC(SETTLE), .CNT_W(CW), .LFSR_SEED(5'h1F)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .mode(mode),
    .num_vec(num_vec), .stim(stim), .resp(resp), .busy(busy), .done(done),
    .pass(pass), .err_cnt(err_cnt), .vec_cnt(vec_cnt), .fail_valid(fail_valid),
    .fail_stim(fail_stim), .fail_resp(fail_resp)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // c17 written as sum-of-products; returns {O23, O22}.
  function automatic logic [1:0] c17_ref(input logic [4:0] v);
    logic i1, i2, i3, i6, i7, o22, o23;
    {i7, i6, i3, i2, i1} = v;
    o22 = (i1 & i3) | (i2 & ~(i3 & i6));
    o23 = ~(i3 & i6) & (i2 | i7);
    return {o23, o22};
  endfunction

  function automatic logic [1:0] c17_faulty(input logic [4:0] v, input int f);
    logic [1:0] r;
    r = c17_ref(v);
    if (f == 1) r[1] = 1'b0;
    if (f == 2) r[0] = 1'b1;
    return r;
  endfunction

  always_comb resp = c17_faulty(stim, fault);

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Expected stimulus order and the run result, derived from the rules alone.
  task automatic build_expect(input bit m, input int nv, input int f, output run_exp_t r);
    int n, v;
    n = (nv == 0 || nv > 32) ? 32 : nv;
    v = 5'h1F;
    r.err = 0; r.vc = n; r.fv = 0; r.fs = 0; r.fr = 0;
    for (int i = 0; i < n; i++) begin
      vec_exp_t e;
      logic [4:0] s;
      s = m ? 5'(v) : 5'(i);
      if (c17_faulty(s, f) != c17_ref(s)) begin
        if (r.err < 255) r.err++;
        if (!r.fv) begin r.fv = 1; r.fs = s; r.fr = c17_faulty(s, f); end
      end
      e.stim = s;
      e.err  = r.err;
      vq.push_back(e);
      v = ((v << 1) & 31) | (((v >> 4) ^ (v >> 2)) & 1);
    end
    r.pass = (r.err == 0);
    r.done_cyc = 0;
  endtask

  // Monitor: each captured vector and each DONE pulse is matched to the queue head.
  logic [5:0] prev_vc = 6'd0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (int'(vec_cnt) == int'(prev_vc) + 1) begin
        if (vq.size() == 0) begin
          chk("vec_unexpected", vec_cnt, 0);
        end else begin
          vec_exp_t e;
          e = vq.pop_front();
          seen.push_back(stim);
          chk("vec_stim", stim, e.stim);
          chk("vec_err_cnt", err_cnt, e.err);
        end
      end
      if (done) begin
        if (rq.size() == 0) begin
          chk("done_unexpected", done, 0);
        end else begin
          run_exp_t r;
          r = rq.pop_front();
          chk("done_cycle", cyc, r.done_cyc);
          chk("done_err_cnt", err_cnt, r.err);
          chk("done_vec_cnt", vec_cnt, r.vc);
          chk("done_fail_valid", fail_valid, r.fv);
          chk("done_fail_stim", fail_stim, r.fs);
          chk("done_fail_resp", fail_resp, r.fr);
          chk("done_busy", busy, 0);
          exp_pass = r.pass;
          pass_pending = 1;
        end
      end else if (pass_pending) begin
        chk("pass", pass, exp_pass);
        pass_pending = 0;
      end
    end
    prev_vc <= vec_cnt;
  end

  task automatic flush();
    vq.delete();
    rq.delete();
    pass_pending = 0;
  endtask

  // Issue START; DONE is due N*(2+SETTLE) edges after the edge that samples START.
  task automatic launch(input bit m, input int nv, input int f);
    run_exp_t r;
    longint   t;
    fault = f;
    build_expect(m, nv, f, r);
    @(negedge clk);
    start = 1; mode = m; num_vec = 6'(nv);
    @(posedge clk); #1;
    t = cyc;
    start = 0; mode = $urandom_range(0, 1); num_vec = 6'($urandom);
    r.done_cyc = t + longint'(r.vc) * (2 + SETTLE);
    rq.push_back(r);
    chk("start_busy", busy, 1);
    chk("start_vec_clr", vec_cnt, 0);
  endtask

  task automatic wait_drain(input string name);
    bit ok = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk); #1;
      if (rq.size() == 0 && !pass_pending) begin ok = 1; break; end
    end
    if (!ok) begin
      chk({name, "_timeout"}, 0, 1);
      flush();
    end
    chk({name, "_vq_drained"}, vq.size(), 0);
  endtask

  task automatic wait_vec(input int n);
    bit ok = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (int'(vec_cnt) == n) begin ok = 1; break; end
    end
    if (!ok) chk("wait_vec_timeout", vec_cnt, n);
  endtask

  initial begin
    int  ndist;
    bit  dup, saw_done;
    int  exp_err;
    rst_n = 0; start = 0; abort = 0; mode = 0; num_vec = 0; fault = 0;
    repeat (3) @(negedge clk);
    chk("rst_stim", stim, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_err", err_cnt, 0);
    chk("rst_vec", vec_cnt, 0);
    chk("rst_fail_valid", fail_valid, 0);
    rst_n = 1;
    repeat (2) @(negedge clk);

    // Exhaustive, fault-free.
    launch(0, 0, 0);
    wait_drain("t1");

    // Exhaustive, O23 stuck-at-0.
    launch(0, 0, 1);
    wait_drain("t2");
    chk("t2_err", err_cnt, 18);
    chk("t2_fail_stim", fail_stim, 5'h02);
    chk("t2_fail_resp", fail_resp, 2'b01);
    chk("t2_pass", pass, 0);

    // LFSR, 31 vectors: all distinct and nonzero, starting from the seed.
    seen.delete();
    launch(1, 31, 0);
    wait_drain("t3");
    dup = 0;
    for (int i = 0; i < seen.size(); i++) begin
      if (seen[i] == 5'd0) dup = 1;
      for (int j = 0; j < i; j++) if (seen[i] == seen[j]) dup = 1;
    end
    ndist = seen.size();
    chk("t3_count", ndist, 31);
    chk("t3_distinct_nonzero", dup, 0);
    if (ndist > 0) chk("t3_first", seen[0], 5'h1F);

    // Short run with a START pulse while busy.
    launch(0, 3, 0);
    repeat (4) @(negedge clk);
    start = 1; mode = 1; num_vec = 6'd7;
    @(negedge clk);
    start = 0;
    wait_drain("t4");
    chk("t4_vec_cnt", vec_cnt, 3);

    // START and ABORT together in IDLE: nothing starts.
    @(negedge clk);
    start = 1; abort = 1;
    @(negedge clk);
    start = 0; abort = 0;
    chk("sa_busy", busy, 0);
    repeat (3) @(negedge clk);
    chk("sa_busy_later", busy, 0);

    // Randomized runs.
    for (int k = 0; k < 6; k++) begin
      launch(1'($urandom_range(0, 1)), int'($urandom_range(0, 63)), int'($urandom_range(0, 2)));
      wait_drain("rand");
    end

    // ABORT during vector 5 of a faulty exhaustive run.
    launch(0, 0, 1);
    wait_vec(5);
    @(negedge clk);
    abort = 1;
    @(negedge clk);
    abort = 0;
    exp_err = 0;
    for (int i = 0; i < 5; i++) if (c17_faulty(5'(i), 1) != c17_ref(5'(i))) exp_err++;
    chk("ab_busy", busy, 0);
    chk("ab_stim", stim, 0);
    chk("ab_done", done, 0);
    chk("ab_vec_cnt", vec_cnt, 5);
    chk("ab_err_cnt", err_cnt, exp_err);
    chk("ab_fail_valid", fail_valid, 1);
    saw_done = 0;
    for (int i = 0; i < 140; i++) begin
      @(negedge clk);
      if (done) saw_done = 1;
    end
    chk("ab_no_done", saw_done, 0);
    chk("ab_pass", pass, 0);
    chk("ab_vec_held", vec_cnt, 5);
    flush();
    launch(0, 4, 0);
    wait_drain("ab_restart");

    // Reset asserted mid-SETTLE.
    launch(1, 0, 2);
    wait_vec(2);
    @(negedge clk);
    #2 rst_n = 0;
    #1;
    chk("mr_stim", stim, 0);
    chk("mr_busy", busy, 0);
    chk("mr_vec", vec_cnt, 0);
    chk("mr_err", err_cnt, 0);
    chk("mr_fail_valid", fail_valid, 0);
    flush();
    @(negedge clk);
    rst_n = 1;
    repeat (2) @(negedge clk);
    seen.delete();
    launch(0, 5, 0);
    wait_drain("mr_restart");
    if (seen.size() > 0) chk("mr_first_vec", seen[0], 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
